// File: rtl/klein_pkg.sv
// KLEIN cipher primitives shared by the byte-serial core and its round function:
// S-box, GF(2^8) column mixing, round-count lookup and the controller state type.
package klein_pkg;

  typedef enum logic [1:0] {
    S_LOAD_KEY,
    S_LOAD_PT,
    S_RUN,
    S_OUT
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h7;
      4'h1: y = 4'h4;
      4'h2: y = 4'hA;
      4'h3: y = 4'h9;
      4'h4: y = 4'h1;
      4'h5: y = 4'hF;
      4'h6: y = 4'hB;
      4'h7: y = 4'h0;
      4'h8: y = 4'hC;
      4'h9: y = 4'h3;
      4'hA: y = 4'h2;
      4'hB: y = 4'h6;
      4'hC: y = 4'h8;
      4'hD: y = 4'hE;
      4'hE: y = 4'hD;
      default: y = 4'h5;
    endcase
    return y;
  endfunction

  function automatic logic [7:0] sbox8(input logic [7:0] x);
    return {sbox(x[7:4]), sbox(x[3:0])};
  endfunction

  // Multiply by 02 in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Circulant (02,03,01,01) on one 4-byte column, byte 0 in the MSBs.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic int nr_of(input int kw);
    case (kw)
      64:      return 12;
      80:      return 16;
      96:      return 20;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/klein_round.sv
// One full KLEIN round plus the matching key-schedule step, purely combinational.
// No latency of its own; the caller registers state_nxt/rk_nxt.
module klein_round
  import klein_pkg::*;
#(
  parameter int KEY_W = 64
) (
  input  logic [63:0]      state,
  input  logic [KEY_W-1:0] rk,
  input  logic [4:0]       rc,
  output logic [63:0]      state_nxt,
  output logic [KEY_W-1:0] rk_nxt
);

  localparam int H = KEY_W / 2;

  logic [63:0]  x, s, r;
  logic [H-1:0] a, b, a_r, b_r, na, nb;

  always_comb begin
    x = state ^ rk[KEY_W-1 -: 64];
    s = '0;
    for (int i = 0; i < 16; i++) begin
      s[4*i +: 4] = sbox(x[4*i +: 4]);
    end
    r         = {s[47:0], s[63:48]};
    state_nxt = {mix_col(r[63:32]), mix_col(r[31:0])};
  end

  // Feistel-like schedule on the two key halves; byte 0 of a half is its MSB byte.
  always_comb begin
    a   = rk[KEY_W-1 -: H];
    b   = rk[H-1:0];
    a_r = {a[H-9:0], a[H-1 -: 8]};
    b_r = {b[H-9:0], b[H-1 -: 8]};
    na  = b_r;
    nb  = a_r ^ b_r;
    na[H-17 -: 8] = na[H-17 -: 8] ^ {3'b000, rc};
    nb[H-9 -: 8]  = sbox8(nb[H-9 -: 8]);
    nb[H-17 -: 8] = sbox8(nb[H-17 -: 8]);
    rk_nxt = {na, nb};
  end

endmodule

// File: rtl/klein_ser_core.sv
// Byte-serial KLEIN-64/80/96 encryptor: key and plaintext in, one round per cycle, ciphertext out.
// dout_valid rises NR edges after the last plaintext byte; dout holds while dout_ready is low.
module klein_ser_core
  import klein_pkg::*;
#(
  parameter int KEY_W = 64
) (
  input  logic       ck,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       key_keep,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_last,
  output logic       busy
);

  localparam int NR = nr_of(KEY_W);
  localparam int KB = KEY_W / 8;

  if (KEY_W != 64 && KEY_W != 80 && KEY_W != 96) begin : g_bad_key_w
    $error("klein_ser_core: KEY_W must be 64, 80 or 96");
  end

  state_t           st, st_nxt;
  logic [KEY_W-1:0] key_mst, rk, rnd_rk;
  logic [63:0]      state, rnd_state, ct, ct_sh;
  logic             key_ok;
  logic [3:0]       kcnt;
  logic [2:0]       pcnt, ocnt;
  logic [4:0]       rc;
  logic             in_hs, out_hs, take_pt;

  klein_round #(.KEY_W(KEY_W)) u_round (
    .state     (state),
    .rk        (rk),
    .rc        (rc),
    .state_nxt (rnd_state),
    .rk_nxt    (rnd_rk)
  );

  assign ct    = state ^ rk[KEY_W-1 -: 64];
  assign ct_sh = ct << {ocnt, 3'b000};

  always_ff @(posedge ck) begin
    if (rst) st <= S_LOAD_KEY;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt     = st;
    din_ready  = 1'b0;
    dout       = 8'h00;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    busy       = 1'b0;
    in_hs      = 1'b0;
    out_hs     = 1'b0;
    take_pt    = 1'b0;
    case (st)
      S_LOAD_KEY: begin
        din_ready = !rst;
        in_hs     = din_valid && !rst;
        // A stored key may be reused only from the very first byte of a block.
        take_pt   = in_hs && (kcnt == 4'd0) && key_keep && key_ok;
        if (take_pt || (in_hs && kcnt == 4'(KB-1))) st_nxt = S_LOAD_PT;
      end
      S_LOAD_PT: begin
        din_ready = !rst;
        in_hs     = din_valid && !rst;
        if (in_hs && pcnt == 3'd7) st_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (rc == 5'(NR)) st_nxt = S_OUT;
      end
      S_OUT: begin
        busy       = 1'b1;
        dout_valid = 1'b1;
        dout       = ct_sh[63:56];
        dout_last  = (ocnt == 3'd7);
        out_hs     = dout_ready;
        if (out_hs && ocnt == 3'd7) st_nxt = S_LOAD_KEY;
      end
      default: st_nxt = S_LOAD_KEY;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      key_mst <= '0;
      rk      <= '0;
      state   <= '0;
      key_ok  <= 1'b0;
      kcnt    <= '0;
      pcnt    <= '0;
      ocnt    <= '0;
      rc      <= '0;
    end else begin
      case (st)
        S_LOAD_KEY: begin
          if (in_hs) begin
            if (take_pt) begin
              state <= {state[55:0], din};
              pcnt  <= 3'd1;
            end else begin
              // key_ok stays low until the final key byte lands.
              key_mst <= {key_mst[KEY_W-9:0], din};
              key_ok  <= (kcnt == 4'(KB-1));
              kcnt    <= (kcnt == 4'(KB-1)) ? 4'd0 : kcnt + 4'd1;
            end
          end
        end
        S_LOAD_PT: begin
          if (in_hs) begin
            state <= {state[55:0], din};
            if (pcnt == 3'd7) begin
              pcnt <= 3'd0;
              rk   <= key_mst;
              rc   <= 5'd1;
            end else begin
              pcnt <= pcnt + 3'd1;
            end
          end
        end
        S_RUN: begin
          state <= rnd_state;
          rk    <= rnd_rk;
          rc    <= rc + 5'd1;
        end
        S_OUT: begin
          if (out_hs) ocnt <= ocnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/klein_ser_core.md
# klein_ser_core

Parametrised KLEIN encryption core with byte-serial I/O, covering KLEIN-64, KLEIN-80 and KLEIN-96.
- Loads a master key and a plaintext block over one 8-bit valid/ready input channel.
- Runs one full KLEIN round per clock on an internal 64-bit state.
- Streams the whitened ciphertext out over an 8-bit valid/ready output channel.
- Sits behind the byte-wide bus interface and replaces the fixed 64-bit-key serialised datapath.
- New behaviour: selectable key size, flow control on both sides, and key reuse across blocks.

## Interface
- KEY_W, 64: key width. Legal values are 64, 80 and 96. Any other value is an elaboration error.
- NR, derived, not overridable: round count. 12, 16 or 20 for KEY_W = 64, 80 or 96.

Ports:
- ck  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- din  in  8  input byte.
- din_valid  in  1  input byte present.
- din_ready  out  1  core accepts din this cycle.
- key_keep  in  1  sampled with the first byte of a block. 1 means reuse the stored key.
- dout  out  8  ciphertext byte.
- dout_valid  out  1  dout is valid.
- dout_ready  in  1  sink accepts dout.
- dout_last  out  1  marks the 8th ciphertext byte.
- busy  out  1  high in S_RUN and S_OUT.

## Operation
- Byte order: MSB-first. Byte 0 is state[63:56] or key[KEY_W-1:KEY_W-8].
- FSM states: S_LOAD_KEY, S_LOAD_PT, S_RUN, S_OUT. Reset state is S_LOAD_KEY.
- A byte transfers on an edge where din_valid && din_ready, or on an edge where dout_valid && dout_ready.
- S_LOAD_KEY:
  - On the first accepted byte of a block, if key_keep=1 and key_ok=1, that byte is taken as plaintext byte 0 and the FSM enters S_LOAD_PT.
  - Otherwise KEY_W/8 bytes shift into key_mst, key_ok is set, and the FSM enters S_LOAD_PT.
- S_LOAD_PT: 8 bytes shift into state. On the 8th byte:
  - working key rk <= key_mst.
  - round counter rc <= 1.
  - FSM enters S_RUN.
- S_RUN: one round per cycle. NR cycles, then the FSM enters S_OUT. Each cycle does:
  - AddRoundKey: x = state ^ rk[KEY_W-1:KEY_W-64].
  - SubNibbles: apply the KLEIN S-box 7,4,A,9,1,F,B,0,C,3,2,6,8,E,D,5 to all 16 nibbles.
  - RotateNibbles: rotate the 64-bit value left by 16 bits.
  - MixNibbles: apply the AES MixColumns circulant (02,03,01,01) over GF(2^8), polynomial 0x11B, independently to bytes 0-3 and bytes 4-7.
  - Key schedule, same cycle:
    - Split rk into halves a (upper) and b (lower). Rotate each half left 1 byte.
    - Set a' = b, b' = a ^ b.
    - XOR rc into byte 2 of a'.
    - Replace bytes 1 and 2 of b' with their S-box values.
    - rk <= {a', b'}.
  - rc increments each cycle; rc is 5 bits wide.
- S_OUT:
  - dout = byte[k] of (state ^ rk[KEY_W-1:KEY_W-64]), where k is the output byte index.
  - k advances on each output handshake.
  - dout_last = (k == 7).
  - After the 8th handshake the FSM enters S_LOAD_KEY.
- key_mst is never modified outside key loading, so key reuse gives identical round keys.

## Timing
- Reset values: din_ready=0 during rst, then 1 in the first cycle after. dout=0, dout_valid=0, dout_last=0, busy=0, key_ok=0, all counters 0.
- din_ready = 1 only in S_LOAD_KEY and S_LOAD_PT. There is no input/output overlap.
- Latency: if edge E accepts the last plaintext byte, dout_valid rises after edge E+NR. Minimum period per block is KEY_W/8 + 8 + NR + 8 cycles.
- Output backpressure: while dout_valid=1 && dout_ready=0, dout and dout_last hold stable.
- din_valid=0 mid-load: byte counters hold and no state changes.
- din_valid is ignored outside load states.
- key_keep is ignored except on the first byte of a block.
- rst mid-block (any state): the next cycle is S_LOAD_KEY with all counters 0 and key_ok=0. A partial key is discarded.

## Structure
- Package klein_pkg:
  - S-box function.
  - xtime/MixColumns function.
  - nr_of(KEY_W) function.
  - FSM state enum.
- Sub-module klein_round (combinational): inputs state, rk, rc. Outputs next state and next rk. Parametrised by KEY_W.
- Top level: FSM, shift-in registers, counters, output mux.

## Test plan
- KLEIN-64: key 0000000000000000, pt FFFFFFFFFFFFFFFF -> ct CDC0B51F14722BBE. dout_valid rises exactly 12 edges after the last pt byte.
- KLEIN-64: key FFFFFFFFFFFFFFFF, pt 0000000000000000 -> 6456764E8602E154. Then key_keep=1 with key 1234567890ABCDEF is not loaded. Check that 8 more bytes are taken as pt and the result uses the stored key (golden model).
- KEY_W=80 and KEY_W=96: all-zero key, pt FFFFFFFFFFFFFFFF -> match the golden model's KLEIN-80 and KLEIN-96 published vectors. Latency is 16 and 20 cycles respectively.
- Random din_valid gaps (~50%) and dout_ready stalls (~50%) over 1000 random blocks.
  - Results must match the golden model.
  - dout must be stable under stall.
  - dout_last is asserted only on byte 7.
- Reset asserted mid-key, mid-run and mid-output.
  - Outputs return to reset values after one edge.
  - key_keep=1 after reset is ignored (key_ok=0) and a full key load is required.
